// File: rtl/hazard_stall_ctrl_if.sv
// Sequencing bundle between the hazard controller and the pipeline.
// Ports: ID/EX hazard inputs, imem/md status in; PC/IF/ID/ID-EX controls out.
interface hazard_stall_ctrl_if #(
    parameter int STALL_W = 16
);
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic               id_is_md;
    logic               jump_id;
    logic               ex_memread;
    logic [4:0]         ex_rt;
    logic               branch_taken_ex;
    logic               imem_ready;
    logic               md_done;
    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_bubble;
    logic               md_start;
    logic               md_err;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_is_md, jump_id, ex_memread, ex_rt,
        output branch_taken_ex, imem_ready, md_done,
        input  pc_en, ifid_en, ifid_flush, idex_bubble,
        input  md_start, md_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_is_md, jump_id, ex_memread, ex_rt,
        input  branch_taken_ex, imem_ready, md_done,
        output pc_en, ifid_en, ifid_flush, idex_bubble,
        output md_start, md_err, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use, redirect, imem wait, mult/div.
// Ports: clk, rst (sync, active-high), hif (slave side of the bundle).
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int TO_W       = 7,
    parameter int STALL_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_stall_ctrl_if.slave hif
);
    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TO_W-1:0]    wd_q;
    logic [TO_W-1:0]    wd_d;
    logic [STALL_W-1:0] cnt_q;
    logic               err_q;
    logic               err_set;
    logic               lu;
    logic               rs_hit;
    logic               rt_hit;
    logic               wd_expire;
    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_bubble;
    logic               md_start;

    assign rs_hit = hif.id_uses_rs && (hif.id_rs == hif.ex_rt);
    assign rt_hit = hif.id_uses_rt && (hif.id_rt == hif.ex_rt);
    assign lu     = hif.ex_memread && (hif.ex_rt != 5'd0)
                    && (rs_hit || rt_hit);

    assign wd_expire = (wd_q == TO_W'(MD_TIMEOUT - 1));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        err_set     = 1'b0;
        state_d     = state_q;
        wd_d        = wd_q;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
            wd_d        = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hif.branch_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (hif.id_is_md) begin
                        md_start    = 1'b1;
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        wd_d        = '0;
                        state_d     = MD_BUSY;
                    end else if (hif.jump_id) begin
                        ifid_flush  = 1'b1;
                    end else if (!hif.imem_ready) begin
                        // ID advances; a nop fills IF/ID while PC waits
                        pc_en       = 1'b0;
                        ifid_flush  = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (hif.md_done || wd_expire) begin
                        // release; the fetch side still waits on imem
                        pc_en      = hif.imem_ready;
                        ifid_flush = !hif.imem_ready;
                        err_set    = !hif.md_done;
                        state_d    = RUN;
                    end else begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        wd_d        = wd_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (!pc_en && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign hif.pc_en       = pc_en;
    assign hif.ifid_en     = ifid_en;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.idex_bubble = idex_bubble;
    assign hif.md_start    = md_start;
    assign hif.md_err      = err_q;
    assign hif.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl.
// Two instances share stimulus; the second has a 2-bit stall counter.
module tb_hazard_stall_ctrl;
    localparam int MD_TO = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_stall_ctrl_if #(.STALL_W(16)) hif ();
    hazard_stall_ctrl_if #(.STALL_W(2))  sif ();

    hazard_stall_ctrl #(
        .MD_TIMEOUT(MD_TO), .TO_W(4), .STALL_W(16)
    ) dut (
        .clk(clk), .rst(rst), .hif(hif.slave)
    );

    hazard_stall_ctrl #(
        .MD_TIMEOUT(MD_TO), .TO_W(4), .STALL_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .hif(sif.slave)
    );

    assign sif.id_rs           = hif.id_rs;
    assign sif.id_rt           = hif.id_rt;
    assign sif.id_uses_rs      = hif.id_uses_rs;
    assign sif.id_uses_rt      = hif.id_uses_rt;
    assign sif.id_is_md        = hif.id_is_md;
    assign sif.jump_id         = hif.jump_id;
    assign sif.ex_memread      = hif.ex_memread;
    assign sif.ex_rt           = hif.ex_rt;
    assign sif.branch_taken_ex = hif.branch_taken_ex;
    assign sif.imem_ready      = hif.imem_ready;
    assign sif.md_done         = hif.md_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: mode flag, cycles spent waiting, counters
    bit         m_busy;
    int         m_held;
    bit         m_err;
    int         m_cnt;
    int         m_scnt;
    logic [4:0] e5;
    logic [5:0] e_out;
    bit         e_start;
    bit         e_rel;

    function automatic logic [5:0] got();
        return {hif.pc_en, hif.ifid_en, hif.ifid_flush,
                hif.idex_bubble, hif.md_start, hif.md_err};
    endfunction

    task automatic model_eval();
        bit lu;
        lu = hif.ex_memread && (hif.ex_rt != 0) &&
             ((hif.id_uses_rs && hif.id_rs == hif.ex_rt) ||
              (hif.id_uses_rt && hif.id_rt == hif.ex_rt));
        e_start = 0;
        e_rel   = 0;
        // bits: pc_en ifid_en ifid_flush idex_bubble md_start
        if (rst) e5 = 5'b00110;
        else if (!m_busy) begin
            if (hif.branch_taken_ex)  e5 = 5'b11110;
            else if (lu)              e5 = 5'b00010;
            else if (hif.id_is_md) begin
                e5 = 5'b00011;
                e_start = 1;
            end
            else if (hif.jump_id)     e5 = 5'b11100;
            else if (!hif.imem_ready) e5 = 5'b01100;
            else                      e5 = 5'b11000;
        end else if (hif.md_done || m_held == MD_TO - 1) begin
            e_rel = 1;
            e5 = {hif.imem_ready, 1'b1, !hif.imem_ready, 2'b00};
        end else e5 = 5'b00010;
        e_out = {e5, m_err};
    endtask

    task automatic model_commit();
        if (rst) begin
            m_busy = 0; m_held = 0; m_err = 0;
            m_cnt = 0; m_scnt = 0;
        end else begin
            if (!e5[4]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_scnt < 3) m_scnt++;
            end
            if (e_start) begin
                m_busy = 1;
                m_held = 0;
            end else if (m_busy) begin
                if (e_rel) begin
                    m_busy = 0;
                    if (!hif.md_done) m_err = 1;
                end else m_held++;
            end
        end
    endtask

    task automatic idle();
        rst                 = 1'b0;
        hif.id_rs           = 5'd0;
        hif.id_rt           = 5'd0;
        hif.id_uses_rs      = 1'b0;
        hif.id_uses_rt      = 1'b0;
        hif.id_is_md        = 1'b0;
        hif.jump_id         = 1'b0;
        hif.ex_memread      = 1'b0;
        hif.ex_rt           = 5'd0;
        hif.branch_taken_ex = 1'b0;
        hif.imem_ready      = 1'b1;
        hif.md_done         = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        hif.ex_memread = 1'b1;
        hif.ex_rt      = r;
        hif.id_rs      = r;
        hif.id_uses_rs = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            rst = (i < 2);
            hif.jump_id = 1'b1;
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL reset c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL reset c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) set_lu(5'd8);
            if (i == 2) set_lu(5'd0);
            if (i == 3) begin
                set_lu(5'd9);
                hif.id_uses_rs = 1'b0;
                hif.id_rt      = 5'd9;
                hif.id_uses_rt = 1'b1;
            end
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL load_use c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL load_use c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_branch_over_lu();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_lu(5'd8);
            hif.branch_taken_ex = (i != 1);
            hif.id_is_md        = (i == 2);
            hif.jump_id         = 1'b1;
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL branch c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL branch c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_md_seq();
        for (int i = 0; i < 10; i++) begin
            idle();
            hif.id_is_md = (i == 0);
            // md_done in the launch cycle must be ignored
            hif.md_done  = (i == 0) || (i == 6);
            if (i >= 1 && i <= 6) begin
                hif.branch_taken_ex = 1'b1;
                hif.jump_id         = 1'b1;
            end
            if (i == 8) begin
                hif.id_is_md   = 1'b1;
                hif.imem_ready = 1'b0;
            end
            if (i == 9) begin
                hif.md_done    = 1'b1;
                hif.imem_ready = 1'b0;
            end
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL md_seq c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL md_seq c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 15; i++) begin
            idle();
            hif.id_is_md = (i == 0);
            rst          = (i == 13);
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL watchdog c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL watchdog c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_imem_jump();
        for (int i = 0; i < 6; i++) begin
            idle();
            hif.imem_ready = !(i >= 1 && i <= 3);
            hif.jump_id    = (i == 4);
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL imem_jump c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL imem_jump c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_md();
        for (int i = 0; i < 5; i++) begin
            idle();
            hif.id_is_md = (i == 0);
            rst          = (i == 2);
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL rst_md c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL rst_md c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin
            idle();
            rst = (i == 0);
            if (i >= 1 && i <= 5) set_lu(5'd3);
            #1; model_eval();
            total++;
            if (sif.stall_cnt !== 2'(m_scnt)) begin
                bad++;
                $display("FAIL sat c%0d cnt got=%0d exp=%0d",
                         i, sif.stall_cnt, m_scnt);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL sat c%0d wide got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            idle();
            rst                 = ($urandom_range(0, 49) == 0);
            hif.id_rs           = 5'($urandom_range(0, 3));
            hif.id_rt           = 5'($urandom_range(0, 3));
            hif.ex_rt           = 5'($urandom_range(0, 3));
            hif.id_uses_rs      = 1'($urandom);
            hif.id_uses_rt      = 1'($urandom);
            hif.ex_memread      = ($urandom_range(0, 3) == 0);
            hif.id_is_md        = ($urandom_range(0, 5) == 0);
            hif.jump_id         = ($urandom_range(0, 5) == 0);
            hif.branch_taken_ex = ($urandom_range(0, 7) == 0);
            hif.imem_ready      = ($urandom_range(0, 4) != 0);
            hif.md_done         = ($urandom_range(0, 9) == 0);
            #1; model_eval();
            total++;
            if (got() !== e_out) begin
                bad++;
                $display("FAIL random c%0d ctl got=%b exp=%b",
                         i, got(), e_out);
            end
            total++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL random c%0d cnt got=%0d exp=%0d",
                         i, hif.stall_cnt, m_cnt);
            end
            total++;
            if (sif.stall_cnt !== 2'(m_scnt)) begin
                bad++;
                $display("FAIL random c%0d scnt got=%0d exp=%0d",
                         i, sif.stall_cnt, m_scnt);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        m_busy = 0; m_held = 0; m_err = 0;
        m_cnt = 0; m_scnt = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_over_lu();
        test_md_seq();
        test_watchdog();
        test_imem_jump();
        test_reset_mid_md();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
